view_xform: RTL and testbench

Camera-space transform stage downstream of the button/yaw-pitch control path. It latches the three camera basis vectors (x_vec, y_vec, z_vec) once per frame and streams world-space vertices through a 2-stage pipelined 3x3 fixed-point matrix-vector multiply. The result is view-space vertices for the rasteriser front end, delivered over a valid/ready handshake. Every vertex within a frame uses one consistent basis, even while the user is pressing buttons.

---
 rtl/view_xform.sv | 104 ++++++++++
 tb/tb_view_xform.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/view_xform.sv
// view_xform: latches a per-frame camera basis and streams vertices through a
// 2-stage pipelined 3x3 fixed-point matrix-vector multiply (rev 1.0).
`default_nettype none

module view_xform #(
   parameter int VECTOR_B = 32,
   parameter int FRAC     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [2:0][VECTOR_B-1:0] x_vec,
   input  logic [2:0][VECTOR_B-1:0] y_vec,
   input  logic [2:0][VECTOR_B-1:0] z_vec,
   input  logic                     frame_sync,
   input  logic [2:0][VECTOR_B-1:0] in_vtx,
   input  logic                     in_last,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [2:0][VECTOR_B-1:0] out_vtx,
   output logic                     out_last,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam int PW = 2 * VECTOR_B;
   localparam int SW = PW + 2;
   localparam logic [VECTOR_B-1:0] ONE  = VECTOR_B'(1) << FRAC;
   localparam logic [VECTOR_B-1:0] ZERO = '0;
   // Row 0 = BX, row 1 = BY, row 2 = BZ; column index = vector component.
   localparam logic [2:0][2:0][VECTOR_B-1:0] IDENT =
      {ONE, ZERO, ZERO, ZERO, ONE, ZERO, ZERO, ZERO, ONE};

   logic [2:0][2:0][VECTOR_B-1:0] basis_q, basis_d;
   logic [2:0][2:0][PW-1:0]       prod_q, prod_d;
   logic                          s1_valid_q, s1_last_q;
   logic [2:0][VECTOR_B-1:0]      res_q, res_d;
   logic                          s2_valid_q, s2_last_q;
   logic                          adv;

   assign adv       = out_ready | ~s2_valid_q;
   assign in_ready  = adv;
   assign out_vtx   = res_q;
   assign out_last  = s2_last_q;
   assign out_valid = s2_valid_q;

   always_comb begin
      basis_d = basis_q;
      if (frame_sync) begin
         basis_d = {z_vec, y_vec, x_vec};
      end
   end

   // Products use the basis held before this edge, so a vertex accepted
   // alongside frame_sync still sees the old basis.
   always_comb begin
      prod_d = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            prod_d[r][c] = PW'($signed(basis_q[r][c])) * PW'($signed(in_vtx[c]));
         end
      end
   end

   always_comb begin
      logic signed [SW-1:0] sum;
      res_d = '0;
      sum   = '0;
      for (int r = 0; r < 3; r++) begin
         sum = SW'($signed(prod_q[r][0])) + SW'($signed(prod_q[r][1]))
             + SW'($signed(prod_q[r][2]));
         res_d[r] = VECTOR_B'(sum >>> FRAC);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         basis_q <= IDENT;
      end else begin
         basis_q <= basis_d;
      end
   end

   // Both stages move together; a stall freezes bubbles in place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_q     <= '0;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         res_q      <= '0;
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
      end else if (adv) begin
         prod_q     <= prod_d;
         s1_valid_q <= in_valid;
         s1_last_q  <= in_last;
         res_q      <= res_d;
         s2_valid_q <= s1_valid_q;
         s2_last_q  <= s1_last_q;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_view_xform.sv
// tb_view_xform: randomized and directed stimulus for view_xform, checked
// against a dot-product reference model and an in-order scoreboard.
`default_nettype none

module tb_view_xform;

   localparam int VB = 32;
   localparam int FR = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [2:0][VB-1:0] x_vec, y_vec, z_vec, in_vtx, out_vtx;
   logic frame_sync, in_last, in_valid, in_ready, out_last, out_valid, out_ready;

   view_xform #(.VECTOR_B(VB), .FRAC(FR)) dut (
      .clk(clk), .rst(rst),
      .x_vec(x_vec), .y_vec(y_vec), .z_vec(z_vec), .frame_sync(frame_sync),
      .in_vtx(in_vtx), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
      .out_vtx(out_vtx), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   localparam logic [VB-1:0] ONE = 32'h0001_0000;
   localparam logic [VB-1:0] NEG = 32'hFFFF_0000;

   logic [VB-1:0] mb [3][3];
   logic [2:0][VB-1:0] xs, ys, zs;

   task automatic model_identity();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            mb[r][c] = (r == c) ? ONE : '0;
   endtask

   function automatic logic [VB-1:0] dot(input int r, input logic [2:0][VB-1:0] v);
      logic signed [2*VB+1:0] s;
      s = '0;
      for (int c = 0; c < 3; c++)
         s = s + ($signed({{(VB+2){mb[r][c][VB-1]}}, mb[r][c]})
                * $signed({{(VB+2){v[c][VB-1]}}, v[c]}));
      s = s >>> FR;
      return s[VB-1:0];
   endfunction

   typedef struct {
      logic [2:0][VB-1:0] v;
      logic               l;
      int                 t;
      int                 st;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   stalls = 0;
   logic held   = 1'b0;
   logic acc    = 1'b0;
   logic [2:0][VB-1:0] held_v;
   logic               held_l;

   task automatic step(input logic fs, input logic vld, input logic [2:0][VB-1:0] v,
                       input logic lst, input logic ordy);
      exp_t e;
      @(negedge clk);
      x_vec = xs; y_vec = ys; z_vec = zs;
      frame_sync = fs; in_valid = vld; in_vtx = v; in_last = lst; out_ready = ordy;
      #1;
      if (held) begin
         chk("stall_valid", 128'(out_valid), 128'(1'b1));
         chk("stall_vtx", 128'(out_vtx), 128'(held_v));
         chk("stall_last", 128'(out_last), 128'(held_l));
      end
      chk("in_ready", 128'(in_ready), 128'(!(out_valid && !ordy)));
      acc = vld && in_ready;
      if (acc) begin
         e.v  = {dot(2, v), dot(1, v), dot(0, v)};
         e.l  = lst;
         e.t  = cyc;
         e.st = stalls;
         q.push_back(e);
      end
      if (out_valid && ordy) begin
         if (q.size() == 0) begin
            chk("spurious_out", 128'(1'b1), 128'(1'b0));
         end else begin
            e = q.pop_front();
            chk("out_vtx", 128'(out_vtx), 128'(e.v));
            chk("out_last", 128'(out_last), 128'(e.l));
            chk("latency", 128'(cyc - e.t), 128'(2 + stalls - e.st));
         end
      end
      if (!in_ready) stalls++;
      held   = out_valid && !ordy;
      held_v = out_vtx;
      held_l = out_last;
      if (fs) begin
         for (int c = 0; c < 3; c++) begin
            mb[0][c] = xs[c]; mb[1][c] = ys[c]; mb[2][c] = zs[c];
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic set_identity_xs();
      xs = {32'h0, 32'h0, ONE};
      ys = {32'h0, ONE, 32'h0};
      zs = {ONE, 32'h0, 32'h0};
   endtask

   task automatic set_rotation_xs();
      xs = {32'h0, ONE, 32'h0};
      ys = {32'h0, 32'h0, NEG};
      zs = {ONE, 32'h0, 32'h0};
   endtask

   initial begin
      logic [2:0][VB-1:0] vv;
      int k;
      set_identity_xs();
      x_vec = xs; y_vec = ys; z_vec = zs;
      frame_sync = 0; in_valid = 0; in_vtx = '0; in_last = 0; out_ready = 1;
      model_identity();
      #12;
      chk("rst_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_vtx", 128'(out_vtx), 128'(0));
      chk("rst_last", 128'(out_last), 128'(1'b0));
      chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
      @(negedge clk);
      rst = 1'b0;

      // identity after reset
      step(1'b0, 1'b1, {NEG, 32'h0002_0000, ONE}, 1'b0, 1'b1);
      idle(3);

      // rotation: (2,3,4) -> (3,-2,4)
      set_rotation_xs();
      step(1'b1, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b1, {32'h0004_0000, 32'h0003_0000, 32'h0002_0000}, 1'b1, 1'b1);
      idle(3);

      // same-cycle ordering: A uses identity, B uses rotation
      set_identity_xs();
      step(1'b1, 1'b0, '0, 1'b0, 1'b1);
      set_rotation_xs();
      step(1'b1, 1'b1, {32'h0, 32'h0, ONE}, 1'b0, 1'b1);
      step(1'b0, 1'b1, {32'h0, 32'h0, ONE}, 1'b0, 1'b1);
      idle(3);

      // backpressure: 6 vertices, 5-cycle stall mid-stream
      k = 0;
      for (int n = 0; n < 20; n++) begin
         vv = {32'(k * 3 + 1) << 16, 32'(k * 2 + 5) << 16, 32'(k + 7) << 16};
         step(1'b0, k < 6, vv, k == 5, !(n >= 3 && n < 8));
         if (acc) k++;
      end
      chk("bp_all_sent", 128'(k), 128'(6));
      chk("bp_drained", 128'(q.size()), 128'(0));

      // wrap and negative rounding toward minus infinity
      set_identity_xs();
      xs = {32'h0, 32'h0, 32'h0004_0000};
      step(1'b1, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b1, {32'h0, 32'h0, 32'h4000_0000}, 1'b0, 1'b1);
      xs = {32'h0, 32'h0, 32'h0000_0001};
      step(1'b1, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b1, {32'h0, 32'h0, 32'hFFFF_FFFF}, 1'b0, 1'b1);
      idle(3);

      // randomized stream with random basis reloads, including during stalls
      for (int n = 0; n < 400; n++) begin
         logic fs;
         fs = ($urandom_range(0, 15) == 0);
         if (fs) begin
            for (int c = 0; c < 3; c++) begin
               xs[c] = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(32'($urandom_range(0, 262143))) - 131072);
               ys[c] = $urandom;
               zs[c] = 32'($signed(32'($urandom_range(0, 262143))) - 131072);
            end
         end
         for (int c = 0; c < 3; c++) vv[c] = $urandom;
         step(fs, $urandom_range(0, 3) != 0, vv, $urandom_range(0, 1) != 0,
              $urandom_range(0, 3) != 0);
      end
      idle(4);
      chk("rand_drained", 128'(q.size()), 128'(0));

      // async reset with two vertices in flight
      set_rotation_xs();
      step(1'b1, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b1, {32'h0, 32'h0, ONE}, 1'b1, 1'b1);
      step(1'b0, 1'b1, {32'h0, ONE, 32'h0}, 1'b1, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("pre_rst_valid", 128'(out_valid), 128'(1'b1));
      #1 rst = 1'b1;
      #1;
      chk("arst_valid", 128'(out_valid), 128'(1'b0));
      chk("arst_vtx", 128'(out_vtx), 128'(0));
      chk("arst_last", 128'(out_last), 128'(1'b0));
      q.delete();
      model_identity();
      held = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cyc++;
      step(1'b0, 1'b1, {32'h0003_0000, 32'h0002_0000, ONE}, 1'b0, 1'b1);
      idle(3);
      chk("final_drained", 128'(q.size()), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
